// File: rtl/enemy_target.sv
// enemy_target: shootable enemy that patrols horizontally on the frame clock.
// Detects overlap with the player bullet, answers a hit with a one-frame
// hit_ack, and runs health, a hit-flash window and a death/respawn timer.
//
// Ports:
//   frame_clk         frame-rate clock, all state changes on its rising edge
//   Reset_n           asynchronous active-low reset
//   BulletX/Y/S       bullet centre and half-size
//   bullet_on         bullet is live
//   EnemyX/Y/S        enemy centre and half-size for the colour mapper
//   enemy_on          enemy visible (ALIVE or HIT)
//   flash             alternate-colour request while in HIT
//   hit_ack           one-frame pulse: bullet consumed
//   kill              one-frame pulse: enemy destroyed
//   health            remaining health
//
// state | meaning
// ------+-----------------------------------------------
// ALIVE | moving, hittable
// HIT   | moving, visible, flashing, not hittable
// DEAD  | invisible, stationary, waiting for respawn
module enemy_target #(
  parameter int SPAWN_X        = 320,
  parameter int SPAWN_Y        = 100,
  parameter int ENEMY_SIZE     = 16,
  parameter int X_MIN          = 1,
  parameter int X_MAX          = 639,
  parameter int X_STEP         = 2,
  parameter int MAX_HEALTH     = 3,
  parameter int HIT_FRAMES     = 30,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic       bullet_on,
  output logic [9:0] EnemyX,
  output logic [9:0] EnemyY,
  output logic [9:0] EnemyS,
  output logic       enemy_on,
  output logic       flash,
  output logic       hit_ack,
  output logic       kill,
  output logic [2:0] health
);

  typedef enum logic [1:0] {ALIVE = 2'd0, HIT = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [10:0] SZ      = 11'(ENEMY_SIZE);
  localparam logic [10:0] STEP    = 11'(X_STEP);
  localparam logic [10:0] XMAX    = 11'(X_MAX);
  localparam logic [10:0] XMIN    = 11'(X_MIN);
  localparam logic [9:0]  SPAWN   = 10'(SPAWN_X);
  localparam logic [9:0]  STEP10  = 10'(X_STEP);
  localparam logic [2:0]  HP_MAX  = 3'(MAX_HEALTH);
  localparam logic [7:0]  HIT_CNT = 8'(HIT_FRAMES);
  localparam logic [7:0]  DEAD_CNT = 8'(RESPAWN_FRAMES);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [9:0] x, x_nxt;
  logic       dir_right, dir_nxt;
  logic [2:0] hp, hp_nxt;
  logic       ack_nxt, kill_nxt, flash_nxt;

  // Collision: 11-bit arithmetic, low edges clamped at zero.
  logic [10:0] bx_lo, bx_hi, by_lo, by_hi;
  logic [10:0] ex_lo, ex_hi, ey_lo, ey_hi;
  logic [10:0] x_ext, y_ext;
  logic        overlap, hit;

  assign x_ext = {1'b0, x};
  assign y_ext = 11'(SPAWN_Y);

  always_comb begin
    bx_hi = {1'b0, BulletX} + {1'b0, BulletS};
    bx_lo = (BulletX >= BulletS) ? {1'b0, BulletX - BulletS} : 11'd0;
    by_hi = {1'b0, BulletY} + {1'b0, BulletS};
    by_lo = (BulletY >= BulletS) ? {1'b0, BulletY - BulletS} : 11'd0;
    ex_hi = x_ext + SZ;
    ex_lo = (x_ext >= SZ) ? x_ext - SZ : 11'd0;
    ey_hi = y_ext + SZ;
    ey_lo = (y_ext >= SZ) ? y_ext - SZ : 11'd0;
    overlap = (bx_hi >= ex_lo) && (bx_lo <= ex_hi) &&
              (by_hi >= ey_lo) && (by_lo <= ey_hi);
    hit = (state == ALIVE) && bullet_on && overlap;
  end

  // Patrol step with edge bounce; used in ALIVE and HIT.
  logic [9:0] mv_x;
  logic       mv_dir;

  always_comb begin
    mv_x   = x;
    mv_dir = dir_right;
    if (dir_right) begin
      if (x_ext + SZ + STEP > XMAX) begin
        mv_dir = 1'b0;
        mv_x   = x - STEP10;
      end else begin
        mv_x   = x + STEP10;
      end
    end else begin
      if (x_ext < XMIN + SZ + STEP) begin
        mv_dir = 1'b1;
        mv_x   = x + STEP10;
      end else begin
        mv_x   = x - STEP10;
      end
    end
  end

  // State register
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ALIVE;
      cnt       <= 8'd0;
      x         <= SPAWN;
      dir_right <= 1'b1;
      hp        <= HP_MAX;
      hit_ack   <= 1'b0;
      kill      <= 1'b0;
      flash     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      x         <= x_nxt;
      dir_right <= dir_nxt;
      hp        <= hp_nxt;
      hit_ack   <= ack_nxt;
      kill      <= kill_nxt;
      flash     <= flash_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x;
    dir_nxt   = dir_right;
    hp_nxt    = hp;
    ack_nxt   = 1'b0;
    kill_nxt  = 1'b0;
    case (state)
      ALIVE: begin
        x_nxt   = mv_x;
        dir_nxt = mv_dir;
        if (hit) begin
          ack_nxt = 1'b1;
          if (hp == 3'd1) begin
            hp_nxt    = 3'd0;
            kill_nxt  = 1'b1;
            state_nxt = DEAD;
            cnt_nxt   = DEAD_CNT;
          end else begin
            hp_nxt    = hp - 3'd1;
            state_nxt = HIT;
            cnt_nxt   = HIT_CNT;
          end
        end
      end
      HIT: begin
        x_nxt   = mv_x;
        dir_nxt = mv_dir;
        if (cnt <= 8'd1) begin
          state_nxt = ALIVE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      DEAD: begin
        if (cnt <= 8'd1) begin
          state_nxt = ALIVE;
          cnt_nxt   = 8'd0;
          x_nxt     = SPAWN;
          dir_nxt   = 1'b1;
          hp_nxt    = HP_MAX;
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ALIVE;
        cnt_nxt   = 8'd0;
      end
    endcase
    // Registered so flash tracks the counter parity it is stored alongside.
    flash_nxt = (state_nxt == HIT) && cnt_nxt[0];
  end

  // Outputs
  always_comb begin
    enemy_on = (state != DEAD);
    EnemyX   = x;
    EnemyY   = 10'(SPAWN_Y);
    EnemyS   = 10'(ENEMY_SIZE);
    health   = hp;
  end

endmodule

// File: tb/tb_enemy_target.sv
module tb_enemy_target;

  logic       frame_clk;
  logic       Reset_n;
  logic [9:0] BulletX, BulletY, BulletS;
  logic       bullet_on;
  logic [9:0] EnemyX, EnemyY, EnemyS;
  logic       enemy_on, flash, hit_ack, kill;
  logic [2:0] health;

  logic [9:0] b_x, b_y, b_s;
  logic       b_on, b_flash, b_ack, b_kill;
  logic [2:0] b_health;
  logic       zero_on;

  int n_vec = 0;
  int n_err = 0;
  int ex;

  enemy_target dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .bullet_on(bullet_on),
    .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyS(EnemyS),
    .enemy_on(enemy_on), .flash(flash), .hit_ack(hit_ack), .kill(kill), .health(health)
  );

  enemy_target #(.SPAWN_X(617)) u_bnc (
    .frame_clk(frame_clk), .Reset_n(Reset_n),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .bullet_on(zero_on),
    .EnemyX(b_x), .EnemyY(b_y), .EnemyS(b_s),
    .enemy_on(b_on), .flash(b_flash), .hit_ack(b_ack), .kill(b_kill), .health(b_health)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  initial begin
    Reset_n   = 1'b1;
    zero_on   = 1'b0;
    bullet_on = 1'b0;
    BulletX   = 10'd0;
    BulletY   = 10'd100;
    BulletS   = 10'd4;
    #1 Reset_n = 1'b0;
    #2;
    chk("rst_x", 32'(EnemyX), 320);
    chk("rst_y", 32'(EnemyY), 100);
    chk("rst_s", 32'(EnemyS), 16);
    chk("rst_health", 32'(health), 3);
    chk("rst_on", 32'(enemy_on), 1);
    chk("rst_ack", 32'(hit_ack), 0);
    chk("rst_bnc_x", 32'(b_x), 617);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    // Patrol right from spawn; bounce instance turns at the right edge.
    tick(); chk("mv_x1", 32'(EnemyX), 322); chk("bnc_1", 32'(b_x), 619);
    tick(); chk("mv_x2", 32'(EnemyX), 324); chk("bnc_2", 32'(b_x), 621);
    tick(); chk("mv_x3", 32'(EnemyX), 326); chk("bnc_3", 32'(b_x), 623);
    tick(); chk("mv_x4", 32'(EnemyX), 328); chk("bnc_4", 32'(b_x), 621);
    tick(); chk("mv_x5", 32'(EnemyX), 330); chk("bnc_left", 32'(b_x), 619);

    // Reset mid-run acts without a clock edge.
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(EnemyX), 320);
    chk("mid_rst_health", 32'(health), 3);
    chk("mid_rst_flash", 32'(flash), 0);
    #1 Reset_n = 1'b1;
    tick(); ex = 322; chk("post_rst_x", 32'(EnemyX), ex);

    // Single hit with a small bullet at the enemy centre, held 3 frames.
    BulletX = 10'd322; BulletY = 10'd100; BulletS = 10'd4; bullet_on = 1'b1;
    tick(); ex += 2;
    chk("hit1_ack", 32'(hit_ack), 1);
    chk("hit1_kill", 32'(kill), 0);
    chk("hit1_health", 32'(health), 2);
    chk("hit1_flash", 32'(flash), 0);
    chk("hit1_x", 32'(EnemyX), ex);
    chk("hit1_on", 32'(enemy_on), 1);
    tick(); ex += 2;
    chk("hit1_ack_clr", 32'(hit_ack), 0);
    chk("hit1_flash2", 32'(flash), 1);
    tick(); ex += 2;
    chk("hit1_ack_f3", 32'(hit_ack), 0);
    chk("hit1_flash3", 32'(flash), 0);

    // Oversized bullet overlapping throughout the rest of HIT: must be ignored.
    BulletX = 10'd320; BulletS = 10'd400;
    for (int i = 4; i <= 30; i++) begin
      tick(); ex += 2;
      chk("hitwin_ack", 32'(hit_ack), 0);
      chk("hitwin_health", 32'(health), 2);
      chk("hitwin_flash", 32'(flash), 32'((31 - i) & 1));
    end
    chk("hitwin_x", 32'(EnemyX), ex);
    bullet_on = 1'b0;
    tick(); ex += 2;
    chk("back_alive_flash", 32'(flash), 0);

    // bullet_on=0 while overlapping is never a hit.
    for (int i = 0; i < 10; i++) begin
      tick(); ex += 2;
      chk("off_ack", 32'(hit_ack), 0);
    end
    chk("off_health", 32'(health), 2);

    // Second hit.
    bullet_on = 1'b1;
    tick(); ex += 2;
    chk("hit2_ack", 32'(hit_ack), 1);
    chk("hit2_health", 32'(health), 1);
    chk("hit2_kill", 32'(kill), 0);
    bullet_on = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(); ex += 2;
    end
    chk("hit2_x", 32'(EnemyX), ex);

    // Third hit kills.
    bullet_on = 1'b1;
    tick(); ex += 2;
    chk("kill_ack", 32'(hit_ack), 1);
    chk("kill_pulse", 32'(kill), 1);
    chk("kill_health", 32'(health), 0);
    chk("kill_on", 32'(enemy_on), 0);
    chk("kill_x", 32'(EnemyX), ex);
    tick();
    chk("dead_ack_clr", 32'(hit_ack), 0);
    chk("dead_kill_clr", 32'(kill), 0);
    bullet_on = 1'b0;
    for (int i = 0; i < 118; i++) tick();
    chk("dead_frozen_x", 32'(EnemyX), ex);
    chk("dead_last_on", 32'(enemy_on), 0);
    tick();
    chk("respawn_x", 32'(EnemyX), 320);
    chk("respawn_health", 32'(health), 3);
    chk("respawn_on", 32'(enemy_on), 1);
    tick();
    chk("respawn_move", 32'(EnemyX), 322);

    // Kill again, then reset 50 frames into DEAD.
    for (int h = 0; h < 3; h++) begin
      bullet_on = 1'b1;
      tick();
      chk("rekill_ack", 32'(hit_ack), 1);
      bullet_on = 1'b0;
      if (h < 2) for (int i = 0; i < 30; i++) tick();
    end
    chk("rekill_kill", 32'(kill), 1);
    for (int i = 0; i < 50; i++) tick();
    chk("dead50_on", 32'(enemy_on), 0);
    Reset_n = 1'b0;
    #1;
    chk("deadrst_on", 32'(enemy_on), 1);
    chk("deadrst_health", 32'(health), 3);
    chk("deadrst_x", 32'(EnemyX), 320);
    chk("deadrst_kill", 32'(kill), 0);
    #1 Reset_n = 1'b1;
    tick();
    chk("deadrst_move", 32'(EnemyX), 322);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_target.md
Name: enemy_target

Overview:
- Shootable enemy object. It patrols horizontally and receives the player bullet's position, size and valid flag, then detects overlap each frame.
- On a hit it returns a one-frame hit_ack so the bullet logic clears its shot. It also tracks health, runs a hit-flash invulnerability window and a death/respawn timer, and drives the enemy sprite position for the colour mapper.

Parameters:
- SPAWN_X, 320, X centre at reset and respawn.
- SPAWN_Y, 100, Y centre (constant; the enemy has no vertical motion).
- ENEMY_SIZE, 16, half-width of the square hitbox and sprite.
- X_MIN, 1, leftmost allowed edge.
- X_MAX, 639, rightmost allowed edge.
- X_STEP, 2, pixels moved per frame.
- MAX_HEALTH, 3, hits to kill (1..7).
- HIT_FRAMES, 30, invulnerable/flash frames after a non-lethal hit (1..255).
- RESPAWN_FRAMES, 120, frames spent dead before respawn (1..255).

Ports:
- frame_clk, input, 1, frame-rate clock; all state updates on its rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- BulletX, input, 10, bullet centre X.
- BulletY, input, 10, bullet centre Y.
- BulletS, input, 10, bullet half-size.
- bullet_on, input, 1, bullet is live.
- EnemyX, output, 10, enemy centre X.
- EnemyY, output, 10, enemy centre Y.
- EnemyS, output, 10, constant ENEMY_SIZE.
- enemy_on, output, 1, enemy visible (ALIVE or HIT).
- flash, output, 1, alternate-colour request during HIT.
- hit_ack, output, 1, one-frame pulse: bullet consumed.
- kill, output, 1, one-frame pulse: enemy destroyed (feeds score).
- health, output, 3, remaining health.

Behaviour:

Reset (Reset_n low, asynchronous):
- EnemyX=SPAWN_X, EnemyY=SPAWN_Y.
- State ALIVE, direction right, health=MAX_HEALTH, counter=0.
- hit_ack=0, kill=0, flash=0, enemy_on=1.
- Reset asserted in any state, including mid-HIT or mid-DEAD, forces these values immediately.

States:
- ALIVE: moving, hittable.
- HIT: moving, visible, not hittable.
- DEAD: invisible, stationary, not hittable.

Collision (combinational, computed in 11-bit unsigned with +1 bit so subtraction cannot underflow):
- overlap = (BulletX+BulletS >= EnemyX-ENEMY_SIZE) and (BulletX-BulletS <= EnemyX+ENEMY_SIZE) and the same test on the Y axis, with the left sides clamped at 0.
- hit = ALIVE and bullet_on and overlap.

ALIVE, on an edge where hit=1:
- hit_ack=1 for that one registered frame.
- If health==1: health becomes 0, kill=1, state becomes DEAD, counter=RESPAWN_FRAMES.
- Otherwise: health decrements by 1, state becomes HIT, counter=HIT_FRAMES.

HIT:
- Counter decrements each frame. flash equals counter bit 0, registered.
- When counter reaches 1, the next edge moves to ALIVE with flash=0.
- Bullet overlap in HIT produces no hit_ack and no health change.

DEAD:
- enemy_on=0, no motion, counter decrements.
- When counter reaches 1, the next edge moves to ALIVE with EnemyX=SPAWN_X, direction right, health=MAX_HEALTH.

hit_ack and kill:
- Both are registered outputs.
- Each is high for exactly one frame, then cleared on the following edge.

Motion (every edge while in ALIVE or HIT, including the hit frame):
- Direction right: if EnemyX+ENEMY_SIZE+X_STEP > X_MAX, set direction left and EnemyX -= X_STEP; else EnemyX += X_STEP.
- Direction left: if EnemyX < X_MIN+ENEMY_SIZE+X_STEP, set direction right and EnemyX += X_STEP; else EnemyX -= X_STEP.
- The compare is done in 11 bits.

Other rules:
- A bullet held in overlap across several frames yields only one hit_ack, because the state leaves ALIVE after the first hit.
- bullet_on=0 is never a hit, regardless of position.
- EnemyY never changes.

Test Plan:
- Reset: hold Reset_n=0 mid-run, then release. Required: EnemyX=320, EnemyY=100, EnemyS=16, health=3, enemy_on=1, hit_ack=0; each following frame EnemyX=322, 324, and so on.
- Bounce: SPAWN_X=617, run 4 frames. Required: EnemyX sequence 619, 621, 623, 621, and direction is now left.
- Single hit: bullet_on=1 at (EnemyX, 100), BulletS=4, for 3 frames. Required:
  - hit_ack high for exactly 1 frame, health=2.
  - State HIT with flash toggling each frame.
  - ALIVE again after 30 frames.
- Ignore cases: bullet_on=0 overlapping for 10 frames, then bullet_on=1 overlapping only during HIT. Required: no hit_ack and health unchanged in both cases.
- Kill/respawn: three separated hits. Required:
  - Third hit gives hit_ack=1 and kill=1 in the same frame, health=0, enemy_on=0.
  - EnemyX frozen for 120 frames.
  - Then EnemyX=320, health=3, enemy_on=1.
- Reset mid-DEAD: pull Reset_n low 50 frames into DEAD. Required: enemy_on=1, health=3 and EnemyX=320 immediately, without waiting for a clock edge.
